// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_pkg
// Description : Shared definitions for the multi-cycle multiply/divide unit:
//               MIPS funct codes of the HI/LO instruction class and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

  // funct field values of the HI/LO-class R-type instructions
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // accepting commands
    S_CALC = 2'd1,  // one shift-add / shift-subtract iteration per cycle
    S_FIX  = 2'd2,  // sign correction and HI/LO write
    S_DZ   = 2'd3   // divide-by-zero fast path
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : 2*XLEN-bit work register plus one iteration of either an
//               LSB-first shift-add multiply or a restoring shift-subtract
//               divide.
//               Multiply: load {0, multiplicand}; after XLEN steps the
//                         register holds the full product.
//               Divide  : load {0, dividend}; after XLEN steps the upper half
//                         holds the remainder, the lower half the quotient.
// Ports       : clock, reset      - clock, async active-high reset
//               load_i/load_val_i - overwrite the work register
//               step_i            - perform one iteration this cycle
//               is_div_i          - 1: divide step, 0: multiply step
//               operand_i         - multiplier / divisor magnitude
//               work_o            - current work register
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [2*XLEN-1:0] load_val_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] work_o
);

  logic [2*XLEN-1:0] work_q, work_d;
  logic [2*XLEN-1:0] w_step;
  logic [XLEN:0]     w_sum;   // upper half + addend, with carry
  logic [XLEN:0]     w_top;   // upper half after the left shift
  logic [XLEN:0]     w_diff;  // trial subtraction; MSB is the borrow

  always_comb begin
    w_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, operand_i} : '0);
    w_top  = work_q[2*XLEN-1:XLEN-1];
    w_diff = w_top - {1'b0, operand_i};
    if (is_div_i) begin
      // Restore (keep the plain shift) when the trial subtraction borrows
      if (!w_diff[XLEN]) begin
        w_step = {w_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
      end else begin
        w_step = {work_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new MSB as the pair shifts right
      w_step = {w_sum, work_q[XLEN-1:1]};
    end

    work_d = work_q;
    if (load_i) begin
      work_d = load_val_i;
    end else if (step_i) begin
      work_d = w_step;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work_q <= '0;
    end else begin
      work_q <= work_d;
    end
  end

  assign work_o = work_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Multi-cycle multiply/divide sequencer for the MIPS execute
//               stage. Owns HI/LO, serves mfhi/mflo/mthi/mtlo and stalls
//               HI/LO-class instructions while a result is pending.
// Ports       : clock, reset      - clock, async active-high reset
//               op_valid          - HI/LO-class instruction present
//               Function_opcode   - funct field
//               Read_data_1/2     - rs / rt operands
//               busy, stall, done - status; done is a one-cycle pulse
//               div_zero          - sticky: last div/divu had rt == 0
//               hi, lo            - HI/LO registers
//               mf_data           - combinational mfhi/mflo read data
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [5:0]      Function_opcode,
  input  logic [XLEN-1:0] Read_data_1,
  input  logic [XLEN-1:0] Read_data_2,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mf_data
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   rs_raw_q, rs_raw_d;    // unmodified rs for the div-by-zero HI value
  logic [XLEN-1:0]   opnd_q, opnd_d;        // multiplier / divisor magnitude
  logic              neg_res_q, neg_res_d;  // negate product / quotient
  logic              neg_rem_q, neg_rem_d;  // negate remainder
  logic              is_div_q, is_div_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  logic              w_load, w_step;
  logic [2*XLEN-1:0] w_load_val, w_work, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;
  logic              w_signed, w_div;
  logic [XLEN-1:0]   w_rs_mag, w_rt_mag;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .step_i     (w_step),
    .is_div_i   (is_div_q),
    .operand_i  (opnd_q),
    .work_o     (w_work)
  );

  always_comb begin
    w_signed   = (Function_opcode == FUNC_MULT) || (Function_opcode == FUNC_DIV);
    w_div      = (Function_opcode == FUNC_DIV)  || (Function_opcode == FUNC_DIVU);
    w_rs_mag   = (w_signed && Read_data_1[XLEN-1]) ? -Read_data_1 : Read_data_1;
    w_rt_mag   = (w_signed && Read_data_2[XLEN-1]) ? -Read_data_2 : Read_data_2;
    w_load_val = {{XLEN{1'b0}}, w_rs_mag};

    w_prod = neg_res_q ? -w_work : w_work;
    w_quo  = neg_res_q ? -w_work[XLEN-1:0]      : w_work[XLEN-1:0];
    w_rem  = neg_rem_q ? -w_work[2*XLEN-1:XLEN] : w_work[2*XLEN-1:XLEN];

    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rs_raw_d  = rs_raw_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    w_load    = 1'b0;
    w_step    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (Function_opcode)
            FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
              w_load    = 1'b1;
              opnd_d    = w_rt_mag;
              rs_raw_d  = Read_data_1;
              neg_res_d = w_signed & (Read_data_1[XLEN-1] ^ Read_data_2[XLEN-1]);
              neg_rem_d = w_signed & Read_data_1[XLEN-1];
              is_div_d  = w_div;
              cnt_d     = '0;
              if (w_div && (Read_data_2 == '0)) begin
                state_d = S_DZ;
              end else begin
                state_d = S_CALC;
                if (w_div) begin
                  dz_d = 1'b0;
                end
              end
            end
            FUNC_MTHI: hi_d = Read_data_1;
            FUNC_MTLO: lo_d = Read_data_1;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        cnt_d  = cnt_q + 1'b1;  // wraps to zero on the last iteration
        if (cnt_q == C_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = w_rem;
          lo_d = w_quo;
        end else begin
          hi_d = w_prod[2*XLEN-1:XLEN];
          lo_d = w_prod[XLEN-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DZ: begin
        hi_d    = rs_raw_q;
        lo_d    = '1;
        dz_d    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rs_raw_q  <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rs_raw_q  <= rs_raw_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    case (Function_opcode)
      FUNC_MFHI: mf_data = hi_q;
      FUNC_MFLO: mf_data = lo_q;
      default:   mf_data = '0;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign stall    = busy & op_valid;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq: a table of mult/div
//               vectors with hand-computed HI/LO, plus directed sequences for
//               mt/mf, stall length and reset during an operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [5:0]  Function_opcode = 6'h00;
  logic [31:0] Read_data_1 = '0;
  logic [31:0] Read_data_2 = '0;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo, mf_data;

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .op_valid        (op_valid),
    .Function_opcode (Function_opcode),
    .Read_data_1     (Read_data_1),
    .Read_data_2     (Read_data_2),
    .busy            (busy),
    .stall           (stall),
    .done            (done),
    .div_zero        (div_zero),
    .hi              (hi),
    .lo              (lo),
    .mf_data         (mf_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;  // edges from acceptance to the edge that raises done
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a command for one cycle; returns just after the acceptance edge
  task automatic accept(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clock);
    op_valid        = 1'b1;
    Function_opcode = f;
    Read_data_1     = rs;
    Read_data_2     = rt;
    @(posedge clock);
    #1;
    op_valid        = 1'b0;
    Function_opcode = 6'h00;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  initial begin
    int n;
    int seen;

    vt[0]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vt[1]  = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vt[2]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vt[3]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vt[4]  = '{F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vt[5]  = '{F_MULT,  32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A, 1'b1, 33};
    vt[6]  = '{F_DIVU,  32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0, 33};
    vt[7]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vt[8]  = '{F_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};
    vt[9]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, 33};
    vt[10] = '{F_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1, 33};
    vt[11] = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};

    // Reset state
    #12;
    chk("reset_busy",  {31'b0, busy},     32'h0);
    chk("reset_stall", {31'b0, stall},    32'h0);
    chk("reset_done",  {31'b0, done},     32'h0);
    chk("reset_dz",    {31'b0, div_zero}, 32'h0);
    chk("reset_hi",    hi, 32'h0);
    chk("reset_lo",    lo, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Table-driven mult/div vectors
    for (int i = 0; i < 12; i++) begin
      accept(vt[i].f, vt[i].rs, vt[i].rt);
      chk($sformatf("v%0d_busy_start", i), {31'b0, busy}, 32'h1);
      wait_done(n);
      chk($sformatf("v%0d_latency", i), n, vt[i].lat);
      chk($sformatf("v%0d_busy_end", i), {31'b0, busy}, 32'h0);
      chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
      chk($sformatf("v%0d_dz", i), {31'b0, div_zero}, {31'b0, vt[i].dz});
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
    end

    // mthi / mtlo: written at the edge, no busy, no done
    accept(F_MTHI, 32'hCAFEF00D, 32'h0);
    chk("mthi_hi",   hi, 32'hCAFEF00D);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    chk("mthi_done", {31'b0, done}, 32'h0);
    accept(F_MTLO, 32'h13572468, 32'h0);
    chk("mtlo_lo", lo, 32'h13572468);
    chk("mtlo_hi", hi, 32'hCAFEF00D);

    // mfhi / mflo: combinational, no stall
    @(negedge clock);
    op_valid = 1'b1;
    Function_opcode = F_MFHI;
    #1;
    chk("mfhi_data",  mf_data, 32'hCAFEF00D);
    chk("mfhi_stall", {31'b0, stall}, 32'h0);
    Function_opcode = F_MFLO;
    #1;
    chk("mflo_data", mf_data, 32'h13572468);
    // Unknown funct: no read data and no effect at the edge
    Function_opcode = 6'h20;
    #1;
    chk("unk_data", mf_data, 32'h0);
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    chk("unk_busy", {31'b0, busy}, 32'h0);
    chk("unk_hi",   hi, 32'hCAFEF00D);

    // mflo presented one cycle after mult acceptance stalls until the result lands
    accept(F_MULT, 32'h00000003, 32'h00000004);
    @(posedge clock);
    #1;
    op_valid = 1'b1;
    Function_opcode = F_MFLO;
    n = 0;
    @(negedge clock);
    while (stall && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("stall_cycles",  n, 32);
    chk("stall_busy",    {31'b0, busy}, 32'h0);
    chk("stall_mf_data", mf_data, 32'h0000000C);
    op_valid = 1'b0;
    Function_opcode = 6'h00;

    // Reset during the 10th iteration of divu aborts and clears HI/LO
    accept(F_DIVU, 32'h00000064, 32'h00000007);
    repeat (9) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_hi",   hi, 32'h0);
    chk("abort_lo",   lo, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 32'h0);
    chk("abort_lo_kept", lo, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
